// File: rtl/retire_trace_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : retire_trace_buffer_if
// Brief    : WB retirement record input, trace stream output and status bus.
// Revision : 1.0 - initial release
// ============================================================================
interface retire_trace_buffer_if;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_imm;
    logic [4:0]  in_rs1n;
    logic [4:0]  in_rs2n;
    logic [4:0]  in_rdn;
    logic        in_regwrite;
    logic        in_exit;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_imm;
    logic [4:0]  out_rs1n;
    logic [4:0]  out_rs2n;
    logic [4:0]  out_rdn;
    logic        out_regwrite;
    logic        out_exit;

    logic [31:0] retired_cnt;
    logic [15:0] drop_cnt;
    logic        overflow;
    logic        done;

    modport master (
        output in_valid, in_pc, in_imm, in_rs1n, in_rs2n, in_rdn, in_regwrite, in_exit,
        output out_ready,
        input  out_valid, out_pc, out_imm, out_rs1n, out_rs2n, out_rdn, out_regwrite, out_exit,
        input  retired_cnt, drop_cnt, overflow, done
    );

    modport slave (
        input  in_valid, in_pc, in_imm, in_rs1n, in_rs2n, in_rdn, in_regwrite, in_exit,
        input  out_ready,
        output out_valid, out_pc, out_imm, out_rs1n, out_rs2n, out_rdn, out_regwrite, out_exit,
        output retired_cnt, drop_cnt, overflow, done
    );
endinterface
`default_nettype wire

// File: rtl/retire_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module   : retire_trace_buffer
// Brief    : FIFO of WB retirement records with drop/retire counters and
//            single-capture exit handling that raises done once drained.
// Revision : 1.0 - initial release
// ============================================================================
module retire_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  wire logic clk,
    input  wire logic rst,
    retire_trace_buffer_if.slave bus
);

    localparam int             c_REC_W = 81;
    localparam logic [PTR_W:0] c_FULL  = (PTR_W+1)'(DEPTH);

    localparam logic [1:0] c_RUN   = 2'd0;
    localparam logic [1:0] c_DRAIN = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_stateNext;
    logic [c_REC_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wrPtr;
    logic [PTR_W-1:0]   r_rdPtr;
    logic [PTR_W:0]     r_count;
    logic [PTR_W:0]     w_countNext;
    logic [31:0]        r_retiredCnt;
    logic [15:0]        r_dropCnt;
    logic               r_overflow;

    logic               w_pop;
    logic               w_attempt;
    logic               w_push;
    logic               w_drop;
    logic               w_countRetire;
    logic [c_REC_W-1:0] w_inRec;
    logic [c_REC_W-1:0] w_headRec;

    assign w_inRec = {bus.in_pc, bus.in_imm, bus.in_rs1n, bus.in_rs2n,
                      bus.in_rdn, bus.in_regwrite, bus.in_exit};

    assign w_pop     = (r_count != '0) && bus.out_ready;
    assign w_attempt = (r_state == c_RUN) && bus.in_valid;
    // A full FIFO still takes the record when the head leaves in the same cycle.
    assign w_push    = w_attempt && ((r_count != c_FULL) || w_pop);
    assign w_drop    = w_attempt && !w_push;
    // A refused exit is re-presented by the core, so it is counted only once it lands.
    assign w_countRetire = w_attempt && !(w_drop && bus.in_exit);

    always_comb begin
        w_countNext = r_count;
        if (w_push && !w_pop) begin
            w_countNext = r_count + 1'b1;
        end else if (w_pop && !w_push) begin
            w_countNext = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_RUN;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            c_RUN: begin
                if (w_push && bus.in_exit) begin
                    w_stateNext = c_DRAIN;
                end
            end
            c_DRAIN: begin
                if (w_countNext == '0) begin
                    w_stateNext = c_DONE;
                end
            end
            c_DONE:  w_stateNext = c_DONE;
            default: w_stateNext = c_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr      <= '0;
            r_rdPtr      <= '0;
            r_count      <= '0;
            r_retiredCnt <= '0;
            r_dropCnt    <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_count <= w_countNext;
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            if (w_countRetire) begin
                r_retiredCnt <= r_retiredCnt + 32'd1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_dropCnt != 16'hFFFF) begin
                    r_dropCnt <= r_dropCnt + 16'd1;
                end
            end
        end
    end

    // Storage is deliberately left out of reset; only occupied slots are ever read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= w_inRec;
        end
    end

    assign w_headRec = r_mem[r_rdPtr];

    assign bus.out_valid    = (r_count != '0);
    assign bus.out_pc       = w_headRec[80:49];
    assign bus.out_imm      = w_headRec[48:17];
    assign bus.out_rs1n     = w_headRec[16:12];
    assign bus.out_rs2n     = w_headRec[11:7];
    assign bus.out_rdn      = w_headRec[6:2];
    assign bus.out_regwrite = w_headRec[1];
    assign bus.out_exit     = w_headRec[0];

    assign bus.retired_cnt  = r_retiredCnt;
    assign bus.drop_cnt     = r_dropCnt;
    assign bus.overflow     = r_overflow;
    assign bus.done         = (r_state == c_DONE);

endmodule
`default_nettype wire

// File: tb/tb_retire_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_retire_trace_buffer
// Brief    : Self-checking bench with a queue scoreboard and a vector table.
// Revision : 1.0 - initial release
// ============================================================================
module tb_retire_trace_buffer;

    localparam int c_DEPTH = 16;
    localparam int c_RUN   = 0;
    localparam int c_DRAIN = 1;
    localparam int c_DONE  = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rw;
        logic        ex;
    } rec_t;

    typedef struct {
        logic        vld;
        logic [31:0] pc;
        logic        rdy;
        logic        expValid;
        logic [31:0] expPc;
        logic [31:0] expRet;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    retire_trace_buffer_if bus ();

    retire_trace_buffer #(.DEPTH(c_DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    rec_t        q[$];
    int          mState;
    logic [31:0] mRetired;
    logic [15:0] mDrop;
    logic        mOvf;
    int          mExitPops;
    int          nCmp = 0;
    int          nFail = 0;

    task automatic chk(input string name, input logic [80:0] act, input logic [80:0] exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic rec_t mkRec(input logic [31:0] pc, input logic ex);
        rec_t r;
        r.pc  = pc;
        r.imm = ~pc;
        r.rs1 = pc[6:2];
        r.rs2 = pc[11:7] ^ 5'h15;
        r.rd  = pc[4:0] + 5'd3;
        r.rw  = pc[2];
        r.ex  = ex;
        return r;
    endfunction

    // One clock: model the cycle from current inputs, advance, check status.
    task automatic step();
        rec_t got;
        logic pop;
        logic ok;
        int   pre;
        got = '{bus.out_pc, bus.out_imm, bus.out_rs1n, bus.out_rs2n, bus.out_rdn,
                bus.out_regwrite, bus.out_exit};
        chk("out_valid", 81'(bus.out_valid), 81'(q.size() != 0));
        if (q.size() != 0) chk("head", 81'(got), 81'(q[0]));
        pre = mState;
        pop = (q.size() != 0) && bus.out_ready;
        if (pop) begin
            if (q[0].ex) mExitPops++;
            void'(q.pop_front());
        end
        if (pre == c_RUN && bus.in_valid) begin
            ok = (q.size() < c_DEPTH);
            if (ok) begin
                q.push_back('{bus.in_pc, bus.in_imm, bus.in_rs1n, bus.in_rs2n, bus.in_rdn,
                              bus.in_regwrite, bus.in_exit});
                if (bus.in_exit) mState = c_DRAIN;
            end else begin
                mOvf = 1'b1;
                if (mDrop != 16'hFFFF) mDrop++;
            end
            if (ok || !bus.in_exit) mRetired++;
        end
        if (pre == c_DRAIN && q.size() == 0) mState = c_DONE;
        @(posedge clk);
        #1;
        chk("done", 81'(bus.done), 81'(mState == c_DONE));
        chk("retired_cnt", 81'(bus.retired_cnt), 81'(mRetired));
        chk("drop_cnt", 81'(bus.drop_cnt), 81'(mDrop));
        chk("overflow", 81'(bus.overflow), 81'(mOvf));
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic ex, input logic rdy);
        rec_t r;
        r = mkRec(pc, ex);
        bus.in_valid    = v;
        bus.in_pc       = r.pc;
        bus.in_imm      = r.imm;
        bus.in_rs1n     = r.rs1;
        bus.in_rs2n     = r.rs2;
        bus.in_rdn      = r.rd;
        bus.in_regwrite = r.rw;
        bus.in_exit     = r.ex;
        bus.out_ready   = rdy;
        step();
    endtask

    task automatic doReset();
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_exit   = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        mState = c_RUN;
        mRetired = '0;
        mDrop = '0;
        mOvf = 1'b0;
        mExitPops = 0;
        chk("rst_out_valid", 81'(bus.out_valid), 81'(0));
        chk("rst_done", 81'(bus.done), 81'(0));
        chk("rst_retired", 81'(bus.retired_cnt), 81'(0));
        chk("rst_drop", 81'(bus.drop_cnt), 81'(0));
        chk("rst_overflow", 81'(bus.overflow), 81'(0));
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{1'b1, 32'h0, 1'b1, 1'b1, 32'h0, 32'd1};
        vecs[1] = '{1'b1, 32'h4, 1'b1, 1'b1, 32'h4, 32'd2};
        vecs[2] = '{1'b1, 32'h8, 1'b1, 1'b1, 32'h8, 32'd3};
        vecs[3] = '{1'b0, 32'hC, 1'b1, 1'b0, 32'h0, 32'd3};
        vecs[4] = '{1'b0, 32'hC, 1'b0, 1'b0, 32'h0, 32'd3};

        bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_imm = '0; bus.in_rs1n = '0;
        bus.in_rs2n = '0; bus.in_rdn = '0; bus.in_regwrite = 1'b0; bus.in_exit = 1'b0;
        bus.out_ready = 1'b0;

        // Three in-order pushes with a ready consumer
        doReset();
        for (int i = 0; i < 5; i++) begin
            drive(vecs[i].vld, vecs[i].pc, 1'b0, vecs[i].rdy);
            chk("tbl_valid", 81'(bus.out_valid), 81'(vecs[i].expValid));
            if (vecs[i].expValid) chk("tbl_pc", 81'(bus.out_pc), 81'(vecs[i].expPc));
            chk("tbl_retired", 81'(bus.retired_cnt), 81'(vecs[i].expRet));
        end
        chk("tbl_drop", 81'(bus.drop_cnt), 81'(0));

        // Overfill with consumer stalled, then drain
        doReset();
        for (int i = 0; i < 20; i++) drive(1'b1, 32'h100 + 32'(4 * i), 1'b0, 1'b0);
        chk("ovf_drop", 81'(bus.drop_cnt), 81'(4));
        chk("ovf_retired", 81'(bus.retired_cnt), 81'(20));
        chk("ovf_flag", 81'(bus.overflow), 81'(1));
        chk("ovf_head", 81'(bus.out_pc), 81'(32'h100));
        for (int i = 0; i < 16; i++) drive(1'b0, 32'h0, 1'b0, 1'b1);
        chk("ovf_empty", 81'(bus.out_valid), 81'(0));

        // Push into a full FIFO while popping
        doReset();
        for (int i = 0; i < 16; i++) drive(1'b1, 32'h200 + 32'(4 * i), 1'b0, 1'b0);
        drive(1'b1, 32'h300, 1'b0, 1'b1);
        chk("fullpp_drop", 81'(bus.drop_cnt), 81'(0));
        chk("fullpp_ovf", 81'(bus.overflow), 81'(0));
        chk("fullpp_head", 81'(bus.out_pc), 81'(32'h204));
        for (int i = 0; i < 16; i++) drive(1'b0, 32'h0, 1'b0, 1'b1);
        chk("fullpp_empty", 81'(bus.out_valid), 81'(0));

        // Exit held for 10 cycles behind two buffered records
        doReset();
        drive(1'b1, 32'h10, 1'b0, 1'b0);
        drive(1'b1, 32'h14, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) drive(1'b1, 32'h40, 1'b1, 1'b1);
        chk("exit_once", 81'(mExitPops), 81'(1));
        chk("exit_retired", 81'(bus.retired_cnt), 81'(3));
        chk("exit_done", 81'(bus.done), 81'(1));

        // Exit arriving at a full FIFO
        doReset();
        for (int i = 0; i < 16; i++) drive(1'b1, 32'h400 + 32'(4 * i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h80, 1'b1, 1'b0);
        chk("fexit_drop", 81'(bus.drop_cnt), 81'(3));
        chk("fexit_ret_pre", 81'(bus.retired_cnt), 81'(16));
        for (int k = 0; k < 40 && !bus.done; k++) drive(1'b1, 32'h80, 1'b1, 1'b1);
        chk("fexit_done", 81'(bus.done), 81'(1));
        chk("fexit_once", 81'(mExitPops), 81'(1));
        chk("fexit_retired", 81'(bus.retired_cnt), 81'(17));
        chk("fexit_drop_end", 81'(bus.drop_cnt), 81'(3));

        // Reset while draining with five records buffered
        doReset();
        for (int i = 0; i < 4; i++) drive(1'b1, 32'h500 + 32'(4 * i), 1'b0, 1'b0);
        drive(1'b1, 32'h600, 1'b1, 1'b0);
        chk("mid_valid", 81'(bus.out_valid), 81'(1));
        doReset();
        drive(1'b1, 32'h700, 1'b0, 1'b1);
        chk("post_valid", 81'(bus.out_valid), 81'(1));
        chk("post_pc", 81'(bus.out_pc), 81'(32'h700));
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        chk("post_empty", 81'(bus.out_valid), 81'(0));
        chk("post_done", 81'(bus.done), 81'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/retire_trace_buffer.md
# retire_trace_buffer

Buffers per-instruction retirement records from the write-back stage of the 5-stage RISC-V pipeline and streams them out over a valid/ready interface to the trace/logging consumer.
- Sits directly downstream of the pipeline top and consumes its WB debug outputs.
- Counts retired and dropped instructions.
- Captures the exit (ecall) record exactly once, even though the core freezes its WB outputs after exit.
- Signals completion once the exit record has drained.

## Interface
Parameters:
- DEPTH, 16, FIFO entries; power of two, ≥2
- PTR_W, $clog2(DEPTH), pointer width

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  WB stage holds a valid retired instruction
- in_pc  in  32  PC of retired instruction
- in_imm  in  32  decoded immediate
- in_rs1n, in_rs2n, in_rdn  in  5 each  register numbers
- in_regwrite  in  1  instruction wrote rd
- in_exit  in  1  instruction is the exit instruction; the core holds it and in_valid high indefinitely
- out_valid  out  1  head record available
- out_ready  in  1  consumer accepts head record
- out_pc, out_imm  out  32 each  head record fields
- out_rs1n, out_rs2n, out_rdn  out  5 each  head record fields
- out_regwrite, out_exit  out  1 each  head record fields
- retired_cnt  out  32  valid records seen in RUN, including dropped; wraps mod 2^32
- drop_cnt  out  16  records lost to full FIFO; saturates at 16'hFFFF
- overflow  out  1  sticky; set on first drop
- done  out  1  exit record has been delivered; held until rst

## Operation
- Storage: DEPTH × 81-bit register array (pc, imm, rs1n, rs2n, rdn, regwrite, exit).
  - Write and read pointers are PTR_W bits; count is PTR_W+1 bits.
  - Both pointers wrap from DEPTH-1 to 0.
- FSM states: RUN, DRAIN, DONE.
  - RUN: a push is attempted when in_valid=1.
    - If the push is accepted and in_exit=1 → DRAIN.
    - If the exit record is dropped because the FIFO is full, stay in RUN; the core re-presents it next cycle.
  - DRAIN: all in_* are ignored; no count updates. When the FIFO is empty → DONE.
  - DONE: done=1. Inputs are ignored. Out side is empty.
- Push accepted when: (count<DEPTH) OR (count==DEPTH AND pop this cycle).
- Push refused: the record is discarded, drop_cnt increments (saturating), and overflow is set.
- retired_cnt increments on every in_valid cycle in RUN, except a refused exit record. This makes the exit count exactly once.
- Pop occurs when out_valid & out_ready.
- out_valid = (count≠0). out_* always reflect the head entry; out_* are don't-care when out_valid=0.
- Simultaneous push and pop: count unchanged, both pointers advance.
- There is no fall-through. A record pushed into an empty FIFO appears on out_* the following cycle.

## Timing
- Reset (rst=1 at edge):
  - count=0, pointers=0, state=RUN.
  - out_valid=0, retired_cnt=0, drop_cnt=0, overflow=0, done=0.
  - Array contents are not cleared.
  - Reset mid-operation discards all buffered records immediately.
- Latency in→out: 1 cycle (push at edge N, out_valid=1 after edge N).
- out_* must remain stable while out_valid=1 and out_ready=0.
- DRAIN→DONE: the edge at which count is 0. done=1 is visible the cycle after the last pop.
- Exit captured at edge N: retired_cnt final after edge N; DRAIN from edge N.

## Test plan
- Reset then 3 pushes (pc 0x0, 0x4, 0x8) with out_ready=1 → out_valid rises one cycle after each push; records emerge in order; retired_cnt=3; drop_cnt=0.
- DEPTH=16, out_ready=0, 20 consecutive in_valid cycles → count=16; drop_cnt=4; overflow=1; retired_cnt=20; then out_ready=1 drains pc of the first 16 records in order.
- FIFO full, in_valid=1 and out_ready=1 in the same cycle → push accepted, count stays 16, no drop.
- in_exit=1 with pc=0x40 held for 10 cycles, FIFO holding 2 entries, out_ready=1 → exactly one exit record in the output stream, as the third record; retired_cnt increments once; done=1 the cycle after it is popped.
- FIFO full when the exit record arrives, out_ready=0 for 3 cycles then 1 → drop_cnt=3; exit still captured once after space frees; done eventually 1.
- rst asserted with 5 records buffered and state DRAIN → next cycle out_valid=0, done=0, counters 0, state RUN; a new push behaves normally.
